apx_add_operand_sequencer: RTL and testbench

APX_ADD_OPERAND_SEQUENCER -- requirements
Module: apx_add_operand_sequencer

---
 rtl/apx_add_operand_sequencer.sv | 168 ++++++++++++++++
 tb/tb_apx_add_operand_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apx_add_operand_sequencer.sv
// Operand sequencer: queues operand pairs and holds each on a registered adder for
// HOLD_CYCLES cycles, then captures the result. Optional mismatch monitor: APX_ADD_ERR_MON_EN.
module apx_add_operand_sequencer #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int FIFO_DEPTH         = 4,
    parameter int HOLD_CYCLES        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
    output logic [DATA_PATH_BITWIDTH-1:0] op_a,
    output logic [DATA_PATH_BITWIDTH-1:0] op_b,
    output logic                          op_reg_en,
    input  logic [DATA_PATH_BITWIDTH-1:0] res_c,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] out_a,
    output logic [DATA_PATH_BITWIDTH-1:0] out_b,
    output logic [DATA_PATH_BITWIDTH-1:0] out_c,
    output logic                          busy,
    output logic [15:0]                   err_cnt
);
    localparam int W     = DATA_PATH_BITWIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [7:0]     HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    // operand FIFO; pointers wrap naturally because the depth is a power of two
    pair_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   occ;
    logic             push, pop, full, empty;
    pair_t            head;

    assign full     = (occ == DEPTH_CNT);
    assign empty    = (occ == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{a: in_a, b: in_b};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (PTR_W + 1)'(1);
                2'b01:   occ <= occ - (PTR_W + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    state_t       state, state_nxt;
    logic [7:0]   cnt, cnt_nxt;
    logic [W-1:0] op_a_nxt, op_b_nxt, out_a_nxt, out_b_nxt, out_c_nxt;
    logic         op_reg_en_nxt, out_valid_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_reg_en <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_a      <= op_a_nxt;
            op_b      <= op_b_nxt;
            op_reg_en <= op_reg_en_nxt;
            out_a     <= out_a_nxt;
            out_b     <= out_b_nxt;
            out_c     <= out_c_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        op_a_nxt      = op_a;
        op_b_nxt      = op_b;
        op_reg_en_nxt = op_reg_en;
        out_a_nxt     = out_a;
        out_b_nxt     = out_b;
        out_c_nxt     = out_c;
        out_valid_nxt = out_valid;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop           = 1'b1;
                    op_a_nxt      = head.a;
                    op_b_nxt      = head.b;
                    op_reg_en_nxt = 1'b1;
                    cnt_nxt       = HOLD_LOAD;
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    out_a_nxt     = op_a;
                    out_b_nxt     = op_b;
                    out_c_nxt     = res_c;
                    out_valid_nxt = 1'b1;
                    op_reg_en_nxt = 1'b0;
                    state_nxt     = DONE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            DONE: begin
                // out_valid is high exactly while in DONE, so out_ready alone completes the handshake
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE) || !empty;

`ifdef APX_ADD_ERR_MON_EN
    logic [W-1:0] sum_chk;
    logic         cap;
    logic [15:0]  err_q;

    assign sum_chk = op_a + op_b;
    assign cap     = (state == HOLD) && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else if (cap && (res_c != sum_chk) && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_apx_add_operand_sequencer.sv
// Bench for apx_add_operand_sequencer: transaction-level model checked every cycle, plus
// table vectors and directed multi-cycle sequences (full FIFO, backpressure, reset, monitor).
module tb_apx_add_operand_sequencer;
    localparam int W = 32;
    localparam int D = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, op_reg_en, out_valid, out_ready, busy;
    logic [W-1:0] in_a, in_b, op_a, op_b, res_c, out_a, out_b, out_c;
    logic [15:0]  err_cnt;

    // downstream adder: correct sum unless the bench forces a wrong result
    logic         corrupt;
    logic [W-1:0] res_force;
    assign res_c = corrupt ? res_force : op_a + op_b;

    apx_add_operand_sequencer #(
        .DATA_PATH_BITWIDTH(W), .FIFO_DEPTH(D), .HOLD_CYCLES(H)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .op_a(op_a), .op_b(op_b), .op_reg_en(op_reg_en), .res_c(res_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; } pair_t;
    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] c; } vec_t;

    // reference model: queued pairs, pair on the adder, and engine phase
    // eng: -1 free, 1..H hold cycles remaining, 0 result presented
    pair_t        fifo_q[$];
    pair_t        cur;
    int           eng;
    logic [W-1:0] m_op_a, m_op_b, m_out_a, m_out_b, m_out_c;
    int           m_err;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        fifo_q.delete();
        eng = -1;
        m_op_a = '0; m_op_b = '0; m_out_a = '0; m_out_b = '0; m_out_c = '0;
        m_err = 0;
    endtask

    task automatic check_state();
        chk1("in_ready",  in_ready,  fifo_q.size() < D);
        chk1("busy",      busy,      (eng != -1) || (fifo_q.size() != 0));
        chk1("op_reg_en", op_reg_en, eng > 0);
        chk1("out_valid", out_valid, eng == 0);
        chkw("op_a",  op_a,  m_op_a);
        chkw("op_b",  op_b,  m_op_b);
        chkw("out_a", out_a, m_out_a);
        chkw("out_b", out_b, m_out_b);
        chkw("out_c", out_c, m_out_c);
        chkw("err_cnt", W'(err_cnt), W'(m_err));
    endtask

    // one clock: decide from pre-edge inputs, advance the model, compare #1 after the edge
    task automatic tick();
        bit           push, retire;
        logic [W-1:0] pa, pb, sum, cap_c;
        push   = in_valid && (fifo_q.size() < D);
        retire = (eng == 0) && out_ready;
        pa = in_a; pb = in_b; cap_c = corrupt ? res_force : '0;
        @(posedge clk);
        if (eng == -1) begin
            if (fifo_q.size() != 0) begin
                cur = fifo_q.pop_front();
                m_op_a = cur.a; m_op_b = cur.b;
                eng = H;
            end
        end else if (eng > 0) begin
            eng--;
            if (eng == 0) begin
                sum = cur.a + cur.b;
                m_out_a = cur.a; m_out_b = cur.b;
                m_out_c = corrupt ? cap_c : sum;
`ifdef APX_ADD_ERR_MON_EN
                if (m_out_c != sum && m_err < 65535) m_err++;
`endif
            end
        end else if (retire) begin
            eng = -1;
        end
        if (push) fifo_q.push_back('{pa, pb});
        #1;
        check_state();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) chk1("wait_valid_timeout", out_valid, 1'b1);
    endtask

    task automatic push_one(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic retire_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // asynchronous reset asserted mid-cycle; outputs must clear before the next edge
    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_clear();
        chk1("rst_op_reg_en", op_reg_en, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready",  in_ready,  1'b1);
        chk1("rst_busy",      busy,      1'b0);
        check_state();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // push ps in order while retiring results, checking retire order against ea/ec
    task automatic stream(input pair_t ps[$], input logic [W-1:0] ea[$],
                          input logic [W-1:0] ec[$], input bit rnd);
        int k = 0;
        int guard = 0;
        while ((ps.size() != 0 || k < ea.size()) && guard < 3000) begin
            if (rnd) begin
                in_valid  = (ps.size() != 0) && ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid  = (ps.size() != 0);
                out_ready = 1'b1;
            end
            if (in_valid) begin
                in_a = ps[0].a; in_b = ps[0].b;
            end
            if (out_valid && out_ready && k < ea.size()) begin
                chkw("order_a", out_a, ea[k]);
                chkw("order_c", out_c, ec[k]);
                k++;
            end
            if (in_valid && fifo_q.size() < D) void'(ps.pop_front());
            tick();
            guard++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        if (guard >= 3000) chkw("stream_timeout", W'(k), W'(ea.size()));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t         vt[5];
        pair_t        ps[$];
        logic [W-1:0] ea[$], ec[$];
        int           lat, en;

        vt[0] = '{32'd5,          32'd7,          32'd12};
        vt[1] = '{32'hFFFF_FFFF,  32'd1,          32'd0};
        vt[2] = '{32'h8000_0000,  32'h8000_0000,  32'd0};
        vt[3] = '{32'h1234_5678,  32'h1111_1111,  32'h2345_6789};
        vt[4] = '{32'd0,          32'hDEAD_BEEF,  32'hDEAD_BEEF};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        corrupt = 1'b0; res_force = '0;
        model_clear();
        #1 rst = 1'b0;
        #1;
        chk1("reset_in_ready", in_ready, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        check_state();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // single pairs: latency counted from the accepting edge, enable width, captured values
        for (int i = 0; i < 5; i++) begin
            push_one(vt[i].a, vt[i].b);
            lat = 0; en = 0;
            while (!out_valid && lat < 50) begin
                tick();
                lat++;
                if (op_reg_en) en++;
            end
            chkw("latency", W'(lat), W'(H + 1));
            chkw("en_cycles", W'(en), W'(H));
            chkw("vec_out_c", out_c, vt[i].c);
            chkw("vec_out_a", out_a, vt[i].a);
            chkw("vec_out_b", out_b, vt[i].b);
            tick();
            tick();
            retire_one();
            chk1("vec_idle", busy, 1'b0);
        end

        // backpressure: result held for 10 cycles, next pair issued right after release
        push_one(32'h11, 32'h22);
        push_one(32'h44, 32'h55);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("bp_valid", out_valid, 1'b1);
            chkw("bp_out_c", out_c, 32'h33);
            chk1("bp_no_pop", op_reg_en, 1'b0);
        end
        retire_one();
        chk1("bp_released", out_valid, 1'b0);
        chk1("bp_idle_cycle", op_reg_en, 1'b0);
        tick();
        chk1("bp_next_issue", op_reg_en, 1'b1);
        chkw("bp_next_op_a", op_a, 32'h44);
        ps.delete(); ea.delete(); ec.delete();
        ea.push_back(32'h44); ec.push_back(32'h99);
        stream(ps, ea, ec, 1'b0);

        // full FIFO: one pair goes to the adder, four fill the FIFO, the sixth stalls
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_a = W'(100 + i); in_b = W'(i);
            chk1("full_in_ready", in_ready, i < 5);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk1("full_stall", in_ready, 1'b0);
            tick();
        end
        ps.delete(); ea.delete(); ec.delete();
        ps.push_back('{32'd105, 32'd5});
        for (int i = 0; i < 6; i++) begin
            ea.push_back(W'(100 + i));
            ec.push_back(W'(100 + 2 * i));
        end
        stream(ps, ea, ec, 1'b0);

        // wrap-around: 12 pairs through the depth-4 FIFO
        ps.delete(); ea.delete(); ec.delete();
        for (int i = 0; i < 12; i++) begin
            ps.push_back('{W'(i), W'(2 * i)});
            ea.push_back(W'(i));
            ec.push_back(W'(3 * i));
        end
        stream(ps, ea, ec, 1'b0);

        // mismatch monitor: a wrong sum counts, a sum equal modulo 2^32 does not
        corrupt = 1'b1; res_force = 32'h0000;
        push_one(32'hFFFF, 32'd1);
        wait_valid(lat);
`ifdef APX_ADD_ERR_MON_EN
        chkw("mon_err_hit", W'(err_cnt), 32'd1);
`else
        chkw("mon_tied_zero", W'(err_cnt), 32'd0);
`endif
        retire_one();
        res_force = 32'h1_0000;
        push_one(32'hFFFF, 32'd1);
        wait_valid(lat);
`ifdef APX_ADD_ERR_MON_EN
        chkw("mon_err_hold", W'(err_cnt), 32'd1);
`else
        chkw("mon_tied_zero2", W'(err_cnt), 32'd0);
`endif
        retire_one();
        corrupt = 1'b0;

        // reset during the second hold cycle with two pairs still queued
        in_valid = 1'b1; in_a = 32'hA1; in_b = 32'hB1; tick();
        in_a = 32'hA2; in_b = 32'hB2; tick();
        in_a = 32'hA3; in_b = 32'hB3; tick();
        in_valid = 1'b0;
        chk1("pre_rst_hold", op_reg_en, 1'b1);
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk1("post_rst_no_result", out_valid, 1'b0);
        chk1("post_rst_idle", busy, 1'b0);
        out_ready = 1'b0;

        // reset while a result waits in DONE
        push_one(32'h7, 32'h8);
        wait_valid(lat);
        do_reset();
        tick();
        chk1("rst_done_cleared", out_valid, 1'b0);
        chkw("rst_done_out_c", out_c, 32'd0);

        // randomized traffic and backpressure
        ps.delete(); ea.delete(); ec.delete();
        for (int i = 0; i < 40; i++) begin
            pair_t p;
            p.a = $urandom();
            p.b = $urandom();
            ps.push_back(p);
            ea.push_back(p.a);
            ec.push_back(p.a + p.b);
        end
        stream(ps, ea, ec, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
